bavul_istemci: RTL
==================

BAVUL_ISTEMCI -- requirements
Module: bavul_istemci

Interface
REQ-001 SHALL have parameter MAX_BAVUL, default 4, maximum bags per passenger.
REQ-002 SHALL have parameter ZAMAN_ASIMI, default 15, cycles allowed for the fee unit to assert bitti.
REQ-003 SHALL have port saat, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port yolcu_basla, input, 1, start a passenger transaction.
REQ-006 SHALL have port bavul_sayisi, input, 3, number of bags for this passenger; sampled with yolcu_basla.
REQ-007 SHALL have port agirlik_gecerli, input, 1, scale strobe; agirlik_giris is valid this cycle.
REQ-008 SHALL have port agirlik_giris, input, 6, bag weight from the scale.
REQ-009 SHALL have port basla, output, 1, start request to the fee unit.
REQ-010 SHALL have port agirlik, output, 6, weight presented to the fee unit.
REQ-011 SHALL have port ucret, input, 8, fee returned by the fee unit.
REQ-012 SHALL have port bitti, input, 1, fee unit done; ucret is valid this cycle.
REQ-013 SHALL have port hazir, output, 1, ready to accept a weight.
REQ-014 SHALL have port toplam_ucret, output, 10, accumulated passenger fee.
REQ-015 SHALL have port tamam, output, 1, one-cycle pulse when the passenger is complete.
REQ-016 SHALL have port hata, output, 1, one-cycle pulse for an invalid bag count or a timeout.

Function
REQ-017 SHALL implement states BOSTA, BEKLE_AGIRLIK, GONDER, BEKLE_BITTI, SONUC.
REQ-018 BOSTA/SONUC: on yolcu_basla with 1<=bavul_sayisi<=MAX_BAVUL, SHALL latch the count into kalan, clear toplam_ucret, and go to BEKLE_AGIRLIK.
REQ-019 BOSTA/SONUC: on yolcu_basla with bavul_sayisi 0 or >MAX_BAVUL, SHALL pulse hata for 1 cycle, go to (or stay in) BOSTA, and leave toplam_ucret unchanged.
REQ-020 BEKLE_AGIRLIK: SHALL drive hazir=1; on agirlik_gecerli, SHALL latch agirlik_giris into agirlik and go to GONDER.
REQ-021 agirlik_gecerli outside BEKLE_AGIRLIK SHALL be ignored.
REQ-022 yolcu_basla outside BOSTA/SONUC SHALL be ignored.
REQ-023 GONDER: SHALL drive basla=1 for exactly this one cycle.
REQ-024 GONDER: if bitti=1 in this cycle, SHALL accept ucret at once and skip BEKLE_BITTI (zero-latency responder).
REQ-025 BEKLE_BITTI: basla=0 and agirlik SHALL be held stable until bitti.
REQ-026 Acceptance: toplam_ucret += ucret, zero-extended to 10 bits; no saturation is needed, since 4*255 = 1020 < 1024.
REQ-027 Acceptance: kalan SHALL decrement; next state is SONUC if kalan becomes 0, else BEKLE_AGIRLIK.
REQ-028 Timeout: counting from GONDER, if bitti has not arrived within ZAMAN_ASIMI cycles, SHALL pulse hata and go to BOSTA.
REQ-029 Timeout: toplam_ucret SHALL keep its partial value.
REQ-030 SONUC: SHALL pulse tamam for 1 cycle on entry.
REQ-031 SONUC: toplam_ucret SHALL be held until the next accepted yolcu_basla.
REQ-032 bitti SHALL be ignored in BOSTA, BEKLE_AGIRLIK and SONUC.
REQ-033 Latency from agirlik_gecerli to basla SHALL be exactly 1 cycle.

Reset
REQ-034 reset SHALL force BOSTA and set basla=0, agirlik=0, hazir=0, toplam_ucret=0, tamam=0, hata=0, kalan=0 and the timeout counter to 0.
REQ-035 reset SHALL take priority over all other inputs in the same cycle, including mid-transaction.

Structure
REQ-036 Package bavul_pkg SHALL hold the state enum and the widths AGIRLIK_W=6, UCRET_W=8, TOPLAM_W=10.
REQ-037 The fee unit and this block SHALL share bavul_pkg.
REQ-038 The timeout counter SHALL be the sub-module bavul_zamanlayici, with inputs baslat and temizle and output doldu.

Verification
REQ-039 Bench SHALL use a fee-unit model with 2-cycle latency that returns 45 for weight 14 and 101 for weight 45.
REQ-040 Scenario: yolcu_basla, bavul_sayisi=2; weights 14 then 45 -> basla pulses twice; tamam pulses once; toplam_ucret=146.
REQ-041 Scenario: bavul_sayisi=0, then bavul_sayisi=5 -> hata pulses once each; state stays BOSTA; hazir=0.
REQ-042 Scenario: zero-latency model (bitti during GONDER), 1 bag, weight 63, ucret 198 -> toplam_ucret=198; tamam 1 cycle after GONDER.
REQ-043 Scenario: model never asserts bitti -> hata exactly ZAMAN_ASIMI cycles after GONDER; state returns to BOSTA.
REQ-044 Scenario: reset asserted in BEKLE_BITTI with toplam_ucret=45 -> all outputs 0 next cycle; stray bitti afterwards is ignored.
REQ-045 Scenario: agirlik_gecerli pulsed in BOSTA and in BEKLE_BITTI -> no basla and no weight change.

Source files
------------

// File: rtl/bavul_pkg.sv
// Shared definitions for the baggage client and the fee unit it talks to.
// Holds the controller state encoding and the data-path widths.
package bavul_pkg;

  localparam int unsigned AGIRLIK_W = 6;   // bag weight from the scale
  localparam int unsigned UCRET_W   = 8;   // fee per bag from the fee unit
  localparam int unsigned TOPLAM_W  = 10;  // per-passenger fee total

  typedef enum logic [2:0] {
    BOSTA,
    BEKLE_AGIRLIK,
    GONDER,
    BEKLE_BITTI,
    SONUC
  } durum_t;

endpackage

// File: rtl/bavul_zamanlayici.sv
// Fee-unit response timer.
// Ports:
//   saat    - clock
//   reset   - synchronous, active-high reset
//   baslat  - start counting (asserted in the cycle the request is issued)
//   temizle - stop and clear the count (response accepted or timeout taken)
//   doldu   - high in the last cycle the response may still arrive in; the
//             controller reports the timeout on the following cycle
module bavul_zamanlayici #(
  parameter int unsigned ZAMAN_ASIMI = 15
) (
  input  logic saat,
  input  logic reset,
  input  logic baslat,
  input  logic temizle,
  output logic doldu
);

  localparam int unsigned SAYAC_W = $clog2(ZAMAN_ASIMI + 1);

  // Count value equals the number of cycles elapsed since the request cycle;
  // zero means idle.
  logic [SAYAC_W-1:0] sayac_q, sayac_d;

  assign doldu = (sayac_q != '0) && (sayac_q == SAYAC_W'(ZAMAN_ASIMI - 1));

  always_comb begin
    sayac_d = sayac_q;
    if (temizle) begin
      sayac_d = '0;
    end else if (baslat) begin
      sayac_d = SAYAC_W'(1);
    end else if ((sayac_q != '0) && !doldu) begin
      sayac_d = sayac_q + SAYAC_W'(1);
    end
  end

  always_ff @(posedge saat) begin
    if (reset) begin
      sayac_q <= '0;
    end else begin
      sayac_q <= sayac_d;
    end
  end

endmodule

// File: rtl/bavul_istemci.sv
// Baggage check-in client: takes a passenger's bag count, feeds each bag
// weight from the scale to the fee unit and accumulates the returned fees.
// Ports:
//   saat, reset              - clock, synchronous active-high reset
//   yolcu_basla, bavul_sayisi - start a passenger with the given bag count
//   agirlik_gecerli, agirlik_giris - scale strobe and weight
//   basla, agirlik           - request and weight to the fee unit
//   ucret, bitti             - fee and done from the fee unit
//   hazir                    - waiting for a weight
//   toplam_ucret             - accumulated fee of the current passenger
//   tamam, hata              - one-cycle completion / error pulses
module bavul_istemci
  import bavul_pkg::*;
#(
  parameter int unsigned MAX_BAVUL   = 4,
  parameter int unsigned ZAMAN_ASIMI = 15
) (
  input  logic                saat,
  input  logic                reset,
  input  logic                yolcu_basla,
  input  logic [2:0]          bavul_sayisi,
  input  logic                agirlik_gecerli,
  input  logic [AGIRLIK_W-1:0] agirlik_giris,
  output logic                basla,
  output logic [AGIRLIK_W-1:0] agirlik,
  input  logic [UCRET_W-1:0]  ucret,
  input  logic                bitti,
  output logic                hazir,
  output logic [TOPLAM_W-1:0] toplam_ucret,
  output logic                tamam,
  output logic                hata
);

  durum_t               durum_q, durum_d;
  logic [2:0]           kalan_q, kalan_d;
  logic [AGIRLIK_W-1:0] agirlik_q, agirlik_d;
  logic [TOPLAM_W-1:0]  toplam_q, toplam_d;
  logic                 tamam_q, tamam_d;
  logic                 hata_q, hata_d;

  logic sayi_gecerli;
  logic kabul;
  logic baslat, temizle, doldu;

  assign sayi_gecerli = (bavul_sayisi != 3'd0) && (32'(bavul_sayisi) <= MAX_BAVUL);

  bavul_zamanlayici #(
    .ZAMAN_ASIMI(ZAMAN_ASIMI)
  ) u_zamanlayici (
    .saat   (saat),
    .reset  (reset),
    .baslat (baslat),
    .temizle(temizle),
    .doldu  (doldu)
  );

  always_comb begin
    durum_d   = durum_q;
    kalan_d   = kalan_q;
    agirlik_d = agirlik_q;
    toplam_d  = toplam_q;
    tamam_d   = 1'b0;
    hata_d    = 1'b0;
    baslat    = 1'b0;
    temizle   = 1'b0;
    kabul     = 1'b0;

    unique case (durum_q)
      BOSTA, SONUC: begin
        if (yolcu_basla) begin
          if (sayi_gecerli) begin
            kalan_d  = bavul_sayisi;
            toplam_d = '0;
            durum_d  = BEKLE_AGIRLIK;
          end else begin
            hata_d  = 1'b1;
            durum_d = BOSTA;
          end
        end
      end
      BEKLE_AGIRLIK: begin
        if (agirlik_gecerli) begin
          agirlik_d = agirlik_giris;
          durum_d   = GONDER;
        end
      end
      GONDER: begin
        // A zero-latency fee unit answers in the request cycle itself.
        if (bitti) begin
          kabul = 1'b1;
        end else begin
          baslat  = 1'b1;
          durum_d = BEKLE_BITTI;
        end
      end
      BEKLE_BITTI: begin
        // A response arriving in the last allowed cycle still wins.
        if (bitti) begin
          kabul   = 1'b1;
          temizle = 1'b1;
        end else if (doldu) begin
          temizle = 1'b1;
          hata_d  = 1'b1;
          durum_d = BOSTA;
        end
      end
      default: durum_d = BOSTA;
    endcase

    if (kabul) begin
      // 4 * 255 fits in TOPLAM_W bits, so no saturation.
      toplam_d = toplam_q + TOPLAM_W'(ucret);
      kalan_d  = kalan_q - 3'd1;
      if (kalan_q == 3'd1) begin
        durum_d = SONUC;
        tamam_d = 1'b1;
      end else begin
        durum_d = BEKLE_AGIRLIK;
      end
    end
  end

  always_ff @(posedge saat) begin
    if (reset) begin
      durum_q   <= BOSTA;
      kalan_q   <= '0;
      agirlik_q <= '0;
      toplam_q  <= '0;
      tamam_q   <= 1'b0;
      hata_q    <= 1'b0;
    end else begin
      durum_q   <= durum_d;
      kalan_q   <= kalan_d;
      agirlik_q <= agirlik_d;
      toplam_q  <= toplam_d;
      tamam_q   <= tamam_d;
      hata_q    <= hata_d;
    end
  end

  assign basla        = (durum_q == GONDER);
  assign hazir        = (durum_q == BEKLE_AGIRLIK);
  assign agirlik      = agirlik_q;
  assign toplam_ucret = toplam_q;
  assign tamam        = tamam_q;
  assign hata         = hata_q;

endmodule
